conv_border_mask: RTL

Post-processing stage placed directly downstream of the 5x5 convolution filter, on its tx_* video bus. It tracks pixel and line coordinates from the delayed dv/hs/vs strobes and measures active width and height from the previous line and frame. Pixels within BORDER pixels of any frame edge have no valid 5x5 neighbourhood, so the block replaces them with a fixed fill colour. All other pixels and all sync strobes pass through with a fixed one-cycle latency.

---
 rtl/video_pkg.sv | 31 +++
 rtl/video_coord_cnt.sv | 105 ++++++++++
 rtl/conv_border_mask.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared video definitions for the filter post-processing
//                chain: colour bus width, default coordinate width and the
//                kernel radius shared with the convolution delay lines, plus
//                the packed RGB pixel type.
//  Revision    : 1.0  initial release
// ============================================================================
package video_pkg;

    // Colour component width of the video bus.
    localparam int VIDEO_W = 8;

    // Default coordinate / counter width. Largest measurable extent is
    // 2**CW_DEFAULT - 1 pixels or lines.
    localparam int CW_DEFAULT = 12;

    // Kernel radius of the 5x5 convolution. Also sizes the border that has
    // no complete neighbourhood.
    localparam int BORDER_DEFAULT = 2;

    // One pixel of the RGB bus.
    typedef struct packed {
        logic [VIDEO_W-1:0] red;
        logic [VIDEO_W-1:0] green;
        logic [VIDEO_W-1:0] blue;
    } rgb_t;

endpackage : video_pkg
`default_nettype wire

// File: rtl/video_coord_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : video_coord_cnt
//  Description : Pixel / line coordinate tracker driven by dv and vs strobes.
//                Measures the active width of the last completed line and the
//                active height of the last completed frame.
//
//  Ports
//    clk        in   rising-edge clock
//    rst        in   synchronous reset, active low
//    i_dv       in   active-video strobe
//    i_vs       in   vsync strobe
//    o_x        out  index of the current pixel while i_dv=1
//    o_y        out  index of the current line within the frame
//    o_width    out  active pixels in the last completed line
//    o_height   out  active lines in the last completed frame
//    o_valid    out  width/height hold a full-frame measurement
//    o_vs_rise  out  combinational vsync rising edge (this cycle)
//
//  Revision    : 1.0  initial release
// ============================================================================
module video_coord_cnt
    import video_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_dv,
    input  logic          i_vs,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic [CW-1:0] o_width,
    output logic [CW-1:0] o_height,
    output logic          o_valid,
    output logic          o_vs_rise
);

    localparam logic [CW-1:0] c_max = '1;

    logic          r_dv_d;
    logic          r_vs_d;
    logic          r_seen_vs;
    logic          r_valid;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [CW-1:0] r_width;
    logic [CW-1:0] r_height;

    logic          w_dv_fall;
    logic          w_vs_rise;
    logic [CW-1:0] w_y_inc;

    assign w_dv_fall = r_dv_d & ~i_dv;
    assign w_vs_rise = ~r_vs_d & i_vs;

    // Saturating line increment, shared by the line-end update and the
    // frame-end capture when both land on the same cycle.
    assign w_y_inc = (r_y == c_max) ? r_y : r_y + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dv_d    <= 1'b0;
            r_vs_d    <= 1'b0;
            r_seen_vs <= 1'b0;
            r_valid   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_width   <= '0;
            r_height  <= '0;
        end else begin
            r_dv_d <= i_dv;
            r_vs_d <= i_vs;

            // After the last pixel of a line r_x holds the pixel count; it
            // is captured as the width and cleared on the same edge.
            if (w_dv_fall) begin
                r_x     <= '0;
                r_width <= r_x;
            end else if (i_dv && (r_x != c_max)) begin
                r_x <= r_x + 1'b1;
            end

            // Frame end wins over line end for y itself, but a coincident
            // line end is still folded into the captured height.
            if (w_vs_rise) begin
                r_y       <= '0;
                r_height  <= w_dv_fall ? w_y_inc : r_y;
                r_seen_vs <= 1'b1;
                r_valid   <= r_seen_vs;
            end else if (w_dv_fall) begin
                r_y <= w_y_inc;
            end
        end
    end

    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_width   = r_width;
    assign o_height  = r_height;
    assign o_valid   = r_valid;
    assign o_vs_rise = w_vs_rise;

endmodule : video_coord_cnt
`default_nettype wire

// File: rtl/conv_border_mask.sv
`default_nettype none
// ============================================================================
//  Module      : conv_border_mask
//  Description : Replaces pixels within BORDER of any frame edge by a fixed
//                fill colour, since the upstream 5x5 filter has no complete
//                neighbourhood there. Data and sync pass with one cycle of
//                latency. Masking mode only changes at a vsync rising edge.
//
//  Ports
//    clk                          in   rising-edge clock
//    rst                          in   synchronous reset, active low
//    in_red/in_green/in_blue      in   filtered pixel data
//    in_dv/in_hs/in_vs            in   strobes aligned with the data
//    mask_en                      in   masking request, taken at vs rise
//    tx_red/tx_green/tx_blue      out  output pixel data (1-cycle latency)
//    tx_dv/tx_hs/tx_vs            out  strobes delayed by one cycle
//    width_o                      out  active pixels in last line
//    height_o                     out  active lines in last frame
//    meas_valid                   out  width_o/height_o are a full measurement
//
//  Revision    : 1.0  initial release
// ============================================================================
module conv_border_mask
    import video_pkg::*;
#(
    parameter int                 CW     = CW_DEFAULT,
    parameter int                 BORDER = BORDER_DEFAULT,
    parameter logic [VIDEO_W-1:0] FILL_R = 8'h00,
    parameter logic [VIDEO_W-1:0] FILL_G = 8'h00,
    parameter logic [VIDEO_W-1:0] FILL_B = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VIDEO_W-1:0] in_red,
    input  logic [VIDEO_W-1:0] in_green,
    input  logic [VIDEO_W-1:0] in_blue,
    input  logic               in_dv,
    input  logic               in_hs,
    input  logic               in_vs,
    input  logic               mask_en,
    output logic [VIDEO_W-1:0] tx_red,
    output logic [VIDEO_W-1:0] tx_green,
    output logic [VIDEO_W-1:0] tx_blue,
    output logic               tx_dv,
    output logic               tx_hs,
    output logic               tx_vs,
    output logic [CW-1:0]      width_o,
    output logic [CW-1:0]      height_o,
    output logic               meas_valid
);

    // Border compares run one bit wider than the counters so that
    // x + BORDER never wraps near the top of the coordinate range.
    localparam logic [CW:0] c_border = (CW + 1)'(BORDER);
    localparam rgb_t        c_fill   = '{red: FILL_R, green: FILL_G, blue: FILL_B};

    logic [CW-1:0] w_x;
    logic [CW-1:0] w_y;
    logic [CW-1:0] w_width;
    logic [CW-1:0] w_height;
    logic          w_valid;
    logic          w_vs_rise;

    logic [CW:0]   w_x_ext;
    logic [CW:0]   w_y_ext;
    logic [CW:0]   w_w_ext;
    logic [CW:0]   w_h_ext;
    logic          w_border;
    logic          w_mask;

    rgb_t          w_pix_in;
    rgb_t          w_pix_out;

    logic          r_mask_act;
    rgb_t          r_pix;
    logic          r_dv;
    logic          r_hs;
    logic          r_vs;

    video_coord_cnt #(
        .CW (CW)
    ) u_coord (
        .clk       (clk),
        .rst       (rst),
        .i_dv      (in_dv),
        .i_vs      (in_vs),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_width   (w_width),
        .o_height  (w_height),
        .o_valid   (w_valid),
        .o_vs_rise (w_vs_rise)
    );

    assign w_x_ext = {1'b0, w_x};
    assign w_y_ext = {1'b0, w_y};
    assign w_w_ext = {1'b0, w_width};
    assign w_h_ext = {1'b0, w_height};

    // A frame narrower or shorter than 2*BORDER+1 makes the near-edge and
    // far-edge tests overlap, so every pixel falls into the border.
    assign w_border = (w_x_ext < c_border)
                    | ((w_x_ext + c_border) >= w_w_ext)
                    | (w_y_ext < c_border)
                    | ((w_y_ext + c_border) >= w_h_ext);

    // Without a full measurement the geometry is unknown: mask everything.
    assign w_mask = r_mask_act & (~w_valid | w_border);

    assign w_pix_in = '{red: in_red, green: in_green, blue: in_blue};

    always_comb begin
        w_pix_out = '0;
        if (in_dv) begin
            if (w_mask) begin
                w_pix_out = c_fill;
            end else begin
                w_pix_out = w_pix_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mask_act <= 1'b0;
            r_pix      <= '0;
            r_dv       <= 1'b0;
            r_hs       <= 1'b0;
            r_vs       <= 1'b0;
        end else begin
            // Latched only at frame start to avoid tearing mid-frame.
            if (w_vs_rise) begin
                r_mask_act <= mask_en;
            end
            r_pix <= w_pix_out;
            r_dv  <= in_dv;
            r_hs  <= in_hs;
            r_vs  <= in_vs;
        end
    end

    assign tx_red     = r_pix.red;
    assign tx_green   = r_pix.green;
    assign tx_blue    = r_pix.blue;
    assign tx_dv      = r_dv;
    assign tx_hs      = r_hs;
    assign tx_vs      = r_vs;
    assign width_o    = w_width;
    assign height_o   = w_height;
    assign meas_valid = w_valid;

endmodule : conv_border_mask
`default_nettype wire
